// File: rtl/i2c_slave.sv
// I2C slave: synchronized scl/sda, START/STOP detection, 7-bit address match,
// byte receive with ACK, and byte transmit with master ACK/NACK handling.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rw,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        rw_q, rw_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_req_q, tx_req_d;

    logic [7:0]  byte_in;
    logic        last_bit, addr_hit;

    // Synchronizers idle high so reset release never looks like a START.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q[0] <= scl;
            sda_sync_q[0] <= sda_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_sync_q[i] <= scl_sync_q[i-1];
                sda_sync_q[i] <= sda_sync_q[i-1];
            end
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s &  scl_prev_q;
    assign start_det =  scl_s &  sda_prev_q & ~sda_s;
    assign stop_det  =  scl_s & ~sda_prev_q &  sda_s;

    assign byte_in  = {shift_q[6:0], sda_s};
    assign last_bit = (bit_cnt_q == 4'd1);
    assign addr_hit = (byte_in[7:1] == SLAVE_ADDR);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd8;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
        end
    end

    // START/STOP outrank scl edges; the ACK phases use sda_oe_q to tell first fall from second.
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = ADDR;
        end else if (stop_det) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                ADDR:     if (scl_rise && last_bit) state_d = addr_hit ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall && sda_oe_q) state_d = rw_q ? TX : RX;
                RX:       if (scl_rise && last_bit) state_d = RX_ACK;
                RX_ACK:   if (scl_fall && sda_oe_q) state_d = RX;
                TX:       if (scl_rise && last_bit) state_d = TX_ACK;
                TX_ACK:   if (scl_rise)             state_d = sda_s ? IGNORE : TX;
                default:  ;
            endcase
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        if (start_det) begin
            bit_cnt_d = 4'd8;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            bit_cnt_d = 4'd8;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = last_bit ? 4'd8 : bit_cnt_q - 4'd1;
                    if (last_bit) begin
                        busy_d = addr_hit;
                        if (addr_hit) rw_d = sda_s;
                    end
                end
                ADDR_ACK, RX_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd8;
                        if (state_q == ADDR_ACK && rw_q) begin
                            shift_d  = tx_data;
                            tx_req_d = 1'b1;
                            sda_oe_d = ~tx_data[7];
                        end
                    end
                end
                RX: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = last_bit ? 4'd8 : bit_cnt_q - 4'd1;
                    if (last_bit) begin
                        rx_data_d  = byte_in;
                        rx_valid_d = 1'b1;
                    end
                end
                TX: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = last_bit ? 4'd8 : bit_cnt_q - 4'd1;
                    end else if (scl_fall) begin
                        sda_oe_d = ~shift_q[7];
                    end
                end
                TX_ACK: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                    if (scl_rise && !sda_s) begin
                        shift_d   = tx_data;
                        tx_req_d  = 1'b1;
                        bit_cnt_d = 4'd8;
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign rw       = rw_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged master drives directed and random frames;
// expectations come from address/ACK rules, a byte table for reads and a record of bytes written.
module tb_i2c_slave;

    localparam logic [6:0] SLAVE = 7'h2A;
    localparam int         Q     = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl, sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rw;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] tx_src [64];
    logic [5:0] tx_idx     = 6'd0;
    logic [7:0] rx_got [$];
    int         rx_cnt     = 0;
    int         rx_rd      = 0;
    int         oe_cycles  = 0;
    int         viol       = 0;
    logic       scl_prev_m = 1'b1;
    logic       oe_prev_m  = 1'b0;

    assign sda_line = sda_m & ~sda_oe;
    assign tx_data  = tx_src[tx_idx];

    i2c_slave #(.SLAVE_ADDR(SLAVE), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rw       (rw),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Bus monitor: records received bytes, advances the read table, and flags sda_oe moving while scl is high.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_got.push_back(rx_data);
            rx_cnt++;
        end
        if (tx_req === 1'b1) tx_idx = tx_idx + 6'd1;
        if (sda_oe === 1'b1) oe_cycles++;
        if (scl && scl_prev_m && (sda_oe !== oe_prev_m)) viol++;
        scl_prev_m = scl;
        oe_prev_m  = sda_oe;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic i2c_rep_start();
        sda_m = 1'b1; #Q;
        scl   = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl   = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        sda_m = b; #Q;
        scl   = 1'b1; #Q;
        r     = sda_line; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], r);
        xfer_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, r);
            d[i] = r;
        end
        xfer_bit(~master_ack, r);
    endtask

    task automatic do_write(input logic [6:0] addr, input logic [7:0] b0, input int n);
        logic [7:0] sent [8];
        logic       ack;
        logic       hit;
        int         cnt0, oe0;
        hit  = (addr == SLAVE);
        cnt0 = rx_cnt;
        oe0  = oe_cycles;
        i2c_start();
        send_byte({addr, 1'b0}, ack);
        check("w_addr_ack", ack, hit);
        check("w_busy", busy, hit);
        if (hit) check("w_rw", rw, 1'b0);
        for (int j = 0; j < n; j++) begin
            sent[j] = (j == 0) ? b0 : 8'($urandom);
            send_byte(sent[j], ack);
            check("w_data_ack", ack, hit);
        end
        i2c_stop();
        check("w_busy_stop", busy, 1'b0);
        check("w_rx_count", rx_cnt - cnt0, hit ? n : 0);
        if (hit) begin
            for (int j = 0; j < n; j++) begin
                check("w_rx_byte", (rx_got.size() > rx_rd) ? rx_got[rx_rd] : 8'hxx, sent[j]);
                rx_rd++;
            end
        end else begin
            check("w_no_drive", oe_cycles - oe0, 0);
        end
    endtask

    task automatic do_read(input int n);
        logic       ack;
        logic [7:0] d;
        logic [5:0] base;
        base = tx_idx;
        i2c_start();
        send_byte({SLAVE, 1'b1}, ack);
        check("r_addr_ack", ack, 1'b1);
        check("r_rw", rw, 1'b1);
        check("r_busy", busy, 1'b1);
        for (int j = 0; j < n; j++) begin
            read_byte(j < n - 1, d);
            check("r_byte", d, tx_src[base + 6'(j)]);
        end
        check("r_released", sda_oe, 1'b0);
        check("r_tx_req_count", 6'(tx_idx - base), 6'(n));
        i2c_stop();
        check("r_busy_stop", busy, 1'b0);
    endtask

    initial begin
        logic       ack, r, d_ack;
        logic [7:0] d;
        logic [5:0] base;
        int         cnt0;

        for (int i = 0; i < 64; i++) tx_src[i] = 8'($urandom);
        reset = 1'b1;
        scl   = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_sda_oe",   sda_oe,   1'b0);
        check("rst_busy",     busy,     1'b0);
        check("rst_rw",       rw,       1'b0);
        check("rst_rx_data",  rx_data,  8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_req",   tx_req,   1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Addressed write of one byte.
        do_write(SLAVE, 8'hA5, 1);
        check("w_rx_data", rx_data, 8'hA5);

        // Write to another address is ignored.
        do_write(7'h13, 8'($urandom), 1);

        // Read two bytes: master ACKs the first and NACKs the second.
        tx_src[tx_idx]         = 8'h3C;
        tx_src[tx_idx + 6'd1]  = 8'hC3;
        do_read(2);

        // Write then repeated START into a read.
        base = tx_idx;
        i2c_start();
        send_byte({SLAVE, 1'b0}, ack);
        check("rs_w_ack", ack, 1'b1);
        send_byte(8'h11, ack);
        check("rs_data_ack", ack, 1'b1);
        i2c_rep_start();
        check("rs_busy_held", busy, 1'b1);
        send_byte({SLAVE, 1'b1}, ack);
        check("rs_r_ack", ack, 1'b1);
        check("rs_rw", rw, 1'b1);
        check("rs_busy", busy, 1'b1);
        check("rs_rx_data", rx_data, 8'h11);
        rx_rd++;
        read_byte(1'b0, d);
        check("rs_r_byte", d, tx_src[base]);
        i2c_stop();
        check("rs_busy_stop", busy, 1'b0);

        // STOP in the middle of a data byte.
        cnt0 = rx_cnt;
        i2c_start();
        send_byte({SLAVE, 1'b0}, ack);
        check("p_addr_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) xfer_bit(1'($urandom), r);
        i2c_stop();
        check("p_no_rx_valid", rx_cnt - cnt0, 0);
        check("p_busy", busy, 1'b0);
        do_write(SLAVE, 8'h7E, 1);
        check("p_rx_data", rx_data, 8'h7E);

        // Reset while the address ACK is on the bus.
        cnt0 = rx_cnt;
        i2c_start();
        for (int i = 7; i >= 0; i--) xfer_bit(SLAVE[i > 0 ? i - 1 : 0] & (i > 0), r);
        check("ra_ack_driven", sda_oe, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ra_sda_oe",   sda_oe,   1'b0);
        check("ra_busy",     busy,     1'b0);
        check("ra_rw",       rw,       1'b0);
        check("ra_rx_data",  rx_data,  8'h00);
        check("ra_rx_valid", rx_valid, 1'b0);
        check("ra_tx_req",   tx_req,   1'b0);
        @(negedge clk);
        reset = 1'b0;
        xfer_bit(1'b1, r);
        check("ra_ack_slot", r, 1'b1);
        send_byte(8'h5A, d_ack);
        check("ra_ignored_ack", d_ack, 1'b0);
        check("ra_ignored_rx", rx_cnt - cnt0, 0);
        i2c_stop();
        do_write(SLAVE, 8'($urandom), 2);

        // Random traffic.
        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 2))
                0: do_write(SLAVE, 8'($urandom), $urandom_range(1, 3));
                1: begin
                    logic [6:0] a;
                    a = 7'($urandom);
                    if (a == SLAVE) a = a + 7'd1;
                    do_write(a, 8'($urandom), $urandom_range(1, 2));
                end
                default: do_read($urandom_range(1, 3));
            endcase
        end

        check("oe_stable_scl_high", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'h2A, meaning the 7-bit bus address the block responds to.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops in the scl/sda input synchronizers.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all logic on posedge clk; clk SHALL be at least 8x the scl rate.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port scl, input, 1 bit: bus clock, driven by the master.
REQ-006 The block SHALL have port sda_in, input, 1 bit: bus data level as read from the pad.
REQ-007 The block SHALL have port sda_oe, output, 1 bit: open-drain pull-down, where 1 drives the line low and 0 releases it.
REQ-008 The block SHALL have port tx_data, input, 8 bits: byte returned to the master on a read.
REQ-009 The block SHALL have port tx_req, output, 1 bit: one-cycle pulse when tx_data is latched into the shifter.
REQ-010 The block SHALL have port rx_data, output, 8 bits: last byte received on a write.
REQ-011 The block SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data updates.
REQ-012 The block SHALL have port rw, output, 1 bit: R/W bit of the current addressed transfer, where 1 means read.
REQ-013 The block SHALL have port busy, output, 1 bit: high from address match until STOP or until a START addressing another device.

Function
REQ-014 scl and sda_in SHALL pass through SYNC_STAGES flops; edge detection SHALL compare the last two synchronized samples.
REQ-015 A START SHALL be detected when sync sda falls while sync scl is high; a STOP SHALL be detected when sync sda rises while sync scl is high.
REQ-016 The states SHALL be IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK and IGNORE.
REQ-017 A START in any state, including a repeated START, SHALL enter ADDR with bit counter = 8 and sda_oe = 0.
REQ-018 A STOP in any state SHALL enter IDLE with sda_oe = 0 and busy = 0.
REQ-019 Bits SHALL be sampled MSB first on each scl rising edge.
REQ-020 sda_oe SHALL change only on the clk cycle after an scl falling edge is detected, never while scl is high.
REQ-021 In ADDR, after 8 bits, {addr[6:0], rw} SHALL be captured; addr == SLAVE_ADDR SHALL go to ADDR_ACK, set busy = 1 and latch rw; a mismatch SHALL go to IGNORE.
REQ-022 ADDR_ACK SHALL assert sda_oe = 1 from the next scl fall until the following scl fall, which ends the ACK bit.
REQ-023 At the end of ADDR_ACK, the block SHALL go to RX if rw = 0; if rw = 1 it SHALL go to TX, latch tx_data and pulse tx_req.
REQ-024 In RX, after 8 bits, rx_data SHALL update and rx_valid SHALL pulse exactly once, on the cycle the 8th scl rise is detected; the state SHALL then be RX_ACK.
REQ-025 RX_ACK SHALL always ACK, as in ADDR_ACK, and then return to RX; there SHALL be no byte limit.
REQ-026 In TX, sda_oe SHALL equal ~shift[7] for each bit, set after each scl fall; after 8 bits the block SHALL go to TX_ACK with sda_oe = 0.
REQ-027 TX_ACK SHALL sample sda on the scl rise: low (ACK) SHALL reload tx_data, pulse tx_req and return to TX; high (NACK) SHALL go to IGNORE.
REQ-028 IGNORE SHALL hold sda_oe = 0 and wait for START or STOP; busy SHALL stay as set, and SHALL be 0 after an address mismatch.
REQ-029 The bit counter SHALL be 4 bits, count down from 8, and reload at each byte boundary; there SHALL be no wrap into the next byte.
REQ-030 If START/STOP detection and an scl edge occur on the same cycle, START/STOP SHALL take priority.

Reset
REQ-031 While reset is high at posedge clk: state = IDLE, sda_oe = 0, busy = 0, rw = 0, rx_data = 8'h00, rx_valid = 0, tx_req = 0, bit counter = 8, and synchronizer flops = 1.
REQ-032 Reset mid-transfer SHALL release sda within one cycle; the block SHALL ignore bus activity until the next START.

Verification
REQ-033 START, 0x54 (addr 0x2A, write), data 0xA5, STOP -> ACK on both bytes; rx_data = 0xA5; rx_valid pulses exactly once; busy 1->0 at STOP.
REQ-034 START, 0x26 (addr 0x13) -> sda_oe stays 0 for the whole frame; busy = 0; no rx_valid.
REQ-035 START, 0x55 (read), tx_data = 0x3C, master ACK, tx_data = 0xC3, master NACK, STOP -> bus bits 00111100 then 11000011; tx_req pulses twice; sda released after the NACK.
REQ-036 Write 0x11, then repeated START, 0x55 read -> rx_data = 0x11, rw switches to 1, busy stays high across the repeated START.
REQ-037 STOP after 4 data bits, then a new write of 0x7E -> no rx_valid for the partial byte; second transfer yields rx_data = 0x7E.
REQ-038 Reset asserted during ADDR_ACK -> sda_oe = 0 on the next cycle; all outputs at REQ-031 values.
